// File: rtl/aes_job_arbiter_pkg.sv
// Shared types and widths for the AES job arbiter.
package aes_job_arbiter_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    INIT,
    INIT_WAIT,
    NEXT,
    NEXT_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/aes_job_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Two passes: indices at/above the pointer first, then the wrapped ones below it.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (IW'(j) >= i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (IW'(j) < i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES-128 encrypt core between NUM_REQ requesters, round-robin,
// with a one-entry key cache that skips key expansion on a repeated key.
module aes_job_arbiter
  import aes_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ-1:0][AES_KEY_W-1:0] i_req_key,
  input  logic [NUM_REQ-1:0][AES_BLK_W-1:0] i_req_block,
  output logic [NUM_REQ-1:0]                o_rsp_valid,
  input  logic [NUM_REQ-1:0]                i_rsp_ready,
  output logic [AES_BLK_W-1:0]              o_rsp_data,
  input  logic                              i_key_flush,
  output logic                              o_aes_init,
  output logic                              o_aes_next,
  output logic [AES_KEY_W-1:0]              o_aes_key,
  output logic [AES_BLK_W-1:0]              o_aes_block,
  input  logic                              i_aes_ready,
  input  logic [AES_BLK_W-1:0]              i_aes_result,
  output logic                              o_busy,
  output logic [CNT_W-1:0]                  o_key_hits,
  output logic [CNT_W-1:0]                  o_jobs_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_gnt_oh;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [IDX_W-1:0]     r_ptr;
  logic [AES_BLK_W-1:0] r_rsp_data;
  logic [AES_KEY_W-1:0] r_aes_key;
  logic [AES_BLK_W-1:0] r_aes_block;
  logic [AES_KEY_W-1:0] r_cache_key;
  logic                 r_cache_vld;
  logic                 r_flush_pend;
  logic                 r_blank;
  logic                 r_aes_init;
  logic                 r_aes_next;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_key_hits;
  logic [CNT_W-1:0]     r_jobs_done;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_any;
  logic [AES_KEY_W-1:0] w_req_key;
  logic                 w_key_hit;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_req_key = i_req_key[r_gnt_idx];
  assign w_key_hit = r_cache_vld && (r_cache_key == w_req_key);

  // Job sequencer. The core keeps ready high for one cycle after a pulse, so the
  // first cycle of each wait state is blanked. aes_next is raised the cycle after
  // ready is seen in NEXT, and that NEXT cycle is the pulse cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_req_ready  <= '0;
      r_gnt_oh     <= '0;
      r_rsp_valid  <= '0;
      r_gnt_idx    <= '0;
      r_ptr        <= '0;
      r_rsp_data   <= '0;
      r_aes_key    <= '0;
      r_aes_block  <= '0;
      r_cache_key  <= '0;
      r_cache_vld  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_blank      <= 1'b0;
      r_aes_init   <= 1'b0;
      r_aes_next   <= 1'b0;
      r_busy       <= 1'b0;
      r_key_hits   <= '0;
      r_jobs_done  <= '0;
    end else begin
      // A flush mid-job must not disturb the key already expanded for that job.
      if (i_key_flush && (r_state != IDLE)) r_flush_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_flush_pend || i_key_flush) begin
            r_cache_vld  <= 1'b0;
            r_flush_pend <= 1'b0;
          end
          if (w_any) begin
            r_gnt_oh    <= w_gnt;
            r_gnt_idx   <= w_idx;
            r_req_ready <= w_gnt;
            r_busy      <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          r_req_ready <= '0;
          r_aes_key   <= w_req_key;
          r_aes_block <= i_req_block[r_gnt_idx];
          r_ptr       <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
          if (w_key_hit) begin
            if (r_key_hits != '1) r_key_hits <= r_key_hits + 1'b1;
            r_aes_next <= i_aes_ready;
            r_state    <= NEXT;
          end else begin
            r_aes_init <= 1'b1;
            r_state    <= INIT;
          end
        end
        INIT: begin
          r_aes_init  <= 1'b0;
          r_cache_key <= r_aes_key;
          r_cache_vld <= 1'b1;
          r_blank     <= 1'b1;
          r_state     <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (r_blank) begin
            r_blank <= 1'b0;
          end else if (i_aes_ready) begin
            r_aes_next <= 1'b1;
            r_state    <= NEXT;
          end
        end
        NEXT: begin
          if (r_aes_next) begin
            r_aes_next <= 1'b0;
            r_blank    <= 1'b1;
            r_state    <= NEXT_WAIT;
          end else if (i_aes_ready) begin
            r_aes_next <= 1'b1;
          end
        end
        NEXT_WAIT: begin
          if (r_blank) begin
            r_blank <= 1'b0;
          end else if (i_aes_ready) begin
            r_rsp_data  <= i_aes_result;
            r_rsp_valid <= r_gnt_oh;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (|(r_rsp_valid & i_rsp_ready)) begin
            r_rsp_valid <= '0;
            if (r_jobs_done != '1) r_jobs_done <= r_jobs_done + 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_aes_init  = r_aes_init;
  assign o_aes_next  = r_aes_next;
  assign o_aes_key   = r_aes_key;
  assign o_aes_block = r_aes_block;
  assign o_busy      = r_busy;
  assign o_key_hits  = r_key_hits;
  assign o_jobs_done = r_jobs_done;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter with a behavioural AES-128 core model.
module tb_aes_job_arbiter;

  localparam int LAT = 12;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][127:0] req_key = '0;
  logic [1:0][127:0] req_block = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [127:0]     rsp_data;
  logic             key_flush = 1'b0;
  logic             aes_init, aes_next;
  logic [127:0]     aes_key, aes_block, aes_result;
  logic             aes_ready;
  logic             busy;
  logic [15:0]      key_hits, jobs_done;

  int tests = 0;
  int fails = 0;
  int n_init = 0;

  always #5 clk = ~clk;

  aes_job_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_key(req_key), .i_req_block(req_block),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .i_key_flush(key_flush),
    .o_aes_init(aes_init), .o_aes_next(aes_next),
    .o_aes_key(aes_key), .o_aes_block(aes_block),
    .i_aes_ready(aes_ready), .i_aes_result(aes_result),
    .o_busy(busy), .o_key_hits(key_hits), .o_jobs_done(jobs_done)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] x, inv;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      sb[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- core model ----------------
  // Ready stays high in the cycle after a pulse, then drops for LAT-1 cycles.
  // The result is garbage until the operation completes.
  int           core_cnt = 0;
  logic [127:0] core_key = '0;
  logic [127:0] core_res = '0;
  logic [127:0] core_pend = '0;

  assign aes_ready  = (core_cnt == 0) || (core_cnt == LAT);
  assign aes_result = core_res;

  always @(posedge clk) begin
    if (aes_init === 1'b1) begin
      core_key <= aes_key;
      core_cnt <= LAT;
    end else if (aes_next === 1'b1) begin
      core_pend <= aes_encrypt(core_key, aes_block);
      core_res  <= 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      core_cnt  <= LAT;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_res <= core_pend;
    end
  end

  always @(posedge clk) if (aes_init === 1'b1) n_init <= n_init + 1;

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int ch, input logic [127:0] key, input logic [127:0] pt);
    int n;
    req_key[ch]   = key;
    req_block[ch] = pt;
    req_valid[ch] = 1'b1;
    n = 0;
    while (req_ready[ch] !== 1'b1 && n < 50) begin tick(); n++; end
    chk("grant", 128'(req_ready), 128'(1) << ch);
    tick();
    req_valid[ch] = 1'b0;
  endtask

  task automatic finish_job(input int ch, input logic [127:0] exp, input string tag);
    int n;
    n = 0;
    while (rsp_valid[ch] !== 1'b1 && n < 200) begin tick(); n++; end
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(1) << ch);
    chk({tag, "_rsp_data"}, rsp_data, exp);
    rsp_ready[ch] = 1'b1;
    tick();
    rsp_ready[ch] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k3 [2][4];
    logic [127:0] p3 [2][4];
    logic [127:0] exp, first;
    int jidx [2];
    int n0, h0, g, n, bad_data, bad_rr, bad_busy;

    build_sbox();
    tick(); tick(); tick();

    // reset state
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    chk("rst_aes_init", 128'(aes_init), 128'(0));
    chk("rst_aes_key", aes_key, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_jobs_done", 128'(jobs_done), 128'(0));
    rst = 1'b0;
    tick();

    // 1: FIPS-197 C.1 on ch0
    n0 = n_init;
    start_job(0, KEY, PT);
    chk("t1_busy", 128'(busy), 128'(1));
    finish_job(0, CT, "t1");
    chk("t1_inits", 128'(n_init - n0), 128'(1));
    chk("t1_key_hits", 128'(key_hits), 128'(0));
    chk("t1_jobs_done", 128'(jobs_done), 128'(1));
    chk("t1_busy_idle", 128'(busy), 128'(0));

    // 2: same key on ch1 hits the cache
    n0 = n_init;
    start_job(1, KEY, PT);
    finish_job(1, CT, "t2");
    chk("t2_inits", 128'(n_init - n0), 128'(0));
    chk("t2_key_hits", 128'(key_hits), 128'(1));
    chk("t2_jobs_done", 128'(jobs_done), 128'(2));

    // 3: both channels, distinct keys, alternating grants
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 4; j++) begin
        k3[c][j] = KEY ^ 128'(c * 16 + j + 1);
        p3[c][j] = PT ^ (128'(j) << 8) ^ 128'(c + 7);
      end
    n0 = n_init;
    jidx[0] = 0; jidx[1] = 0;
    for (int c = 0; c < 2; c++) begin
      req_key[c]   = k3[c][0];
      req_block[c] = p3[c][0];
    end
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 50) begin tick(); n++; end
      chk("t3_grant", 128'(req_ready), 128'(1) << (i % 2));
      g = (req_ready[1] === 1'b1) ? 1 : 0;
      tick();
      exp = aes_encrypt(k3[g][jidx[g]], p3[g][jidx[g]]);
      jidx[g]++;
      if (jidx[g] < 4) begin
        req_key[g]   = k3[g][jidx[g]];
        req_block[g] = p3[g][jidx[g]];
      end else begin
        req_valid[g] = 1'b0;
      end
      finish_job(g, exp, "t3");
    end
    req_valid = 2'b00;
    chk("t3_inits", 128'(n_init - n0), 128'(8));
    chk("t3_key_hits", 128'(key_hits), 128'(1));

    // 4: response back-pressure with another request waiting
    start_job(0, KEY ^ 128'hff00, PT);
    req_key[1]   = KEY ^ 128'h00ff;
    req_block[1] = PT ^ 128'h55;
    req_valid[1] = 1'b1;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 200) begin tick(); n++; end
    first = rsp_data;
    bad_data = 0; bad_rr = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_data !== first) bad_data++;
      if (req_ready !== 2'b00) bad_rr++;
      if (busy !== 1'b1) bad_busy++;
      tick();
    end
    chk("t4_data_stable", 128'(bad_data), 128'(0));
    chk("t4_no_grant", 128'(bad_rr), 128'(0));
    chk("t4_busy", 128'(bad_busy), 128'(0));
    chk("t4_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("t4_rsp_data", rsp_data, aes_encrypt(KEY ^ 128'hff00, PT));
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    start_job(1, KEY ^ 128'h00ff, PT ^ 128'h55);
    finish_job(1, aes_encrypt(KEY ^ 128'h00ff, PT ^ 128'h55), "t4b");

    // 5: flush during NEXT_WAIT, then same key must re-expand
    start_job(0, KEY, PT);
    n = 0;
    while (aes_next !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    key_flush = 1'b1;
    tick();
    key_flush = 1'b0;
    finish_job(0, CT, "t5a");
    h0 = int'(key_hits);
    n0 = n_init;
    start_job(0, KEY, PT);
    finish_job(0, CT, "t5b");
    chk("t5_inits", 128'(n_init - n0), 128'(1));
    chk("t5_key_hits", 128'(key_hits), 128'(h0));

    // 6: reset during INIT_WAIT
    start_job(0, KEY ^ 128'h1, PT);
    n = 0;
    while (aes_init !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    chk("t6_req_ready", 128'(req_ready), 128'(0));
    chk("t6_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t6_rsp_data", rsp_data, 128'(0));
    chk("t6_aes_init", 128'(aes_init), 128'(0));
    chk("t6_aes_next", 128'(aes_next), 128'(0));
    chk("t6_aes_key", aes_key, 128'(0));
    chk("t6_aes_block", aes_block, 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_key_hits", 128'(key_hits), 128'(0));
    chk("t6_jobs_done", 128'(jobs_done), 128'(0));
    rst = 1'b0;
    n = 0;
    while (aes_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n0 = n_init;
    start_job(0, KEY ^ 128'h1, PT);
    finish_job(0, aes_encrypt(KEY ^ 128'h1, PT), "t6");
    chk("t6_inits", 128'(n_init - n0), 128'(1));
    chk("t6_jobs_after", 128'(jobs_done), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
